pattern_detect_sched: RTL and testbench
=======================================

# pattern_detect_sched

Round-robin scheduler that shares one `moore_nonover` BBCCBC pattern detector (B=0, C=1, non-overlapping, Moore output) among up to eight serial bit-stream requesters. It grants the detector to one requester for a whole frame and steers that requester's bits into it. It resets the detector between frames so no partial match leaks across requesters. Detections are attributed to the owning requester and reported per frame and as per-requester totals.

## Interface
- `N_REQ`, 4: number of requesters, legal range 2..8.
- `CW`, 16: width of each per-requester hit counter.
- `TO_CYC`, 64: stall-timeout threshold in cycles; used only with `PDS_TIMEOUT_EN`.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `req_i` in N_REQ: per-requester "bit available this cycle".
- `data_i` in N_REQ: per-requester serial bit.
- `last_i` in N_REQ: marks the final bit of the requester's frame.
- `clr_cnt_i` in 1: synchronously clears all hit counters.
- `gnt_o` out N_REQ: one-hot owner; a bit transfers when `gnt_o[i] & req_i[i]`.
- `det_rst_o` out 1: to detector `rst_i`.
- `det_valid_o` out 1: to detector `valid_i`.
- `det_data_o` out 1: to detector `data_i`.
- `det_pattern_i` in 1: from detector `pattern_detector_o`.
- `frame_done_o` out 1: one-cycle frame-completion pulse.
- `frame_id_o` out 3: owner index of the completed frame.
- `frame_hits_o` out 8: detections in the completed frame, saturating at 255.
- `frame_abort_o` out 1: completed frame was aborted by timeout.
- `hit_cnt_o` out N_REQ*CW: requester i's counter is bits [i*CW +: CW]; saturating.

## Operation
- **FSM states:** CLEAR, IDLE, BUSY, DRAIN. Reset enters CLEAR.
- **CLEAR:**
  - Drives `det_rst_o`=1; all grants are 0.
  - Clears the edge-detect register and the frame hit count.
  - Always proceeds to IDLE.
  - Pulses `frame_done_o` only when CLEAR is entered from DRAIN or from a timeout abort.
- **IDLE:**
  - If any `req_i` is set, picks the first set bit searching upward from `(last_owner+1) mod N_REQ`.
  - Registers that index as owner and goes to BUSY.
  - After reset, `last_owner` = N_REQ-1, so requester 0 has first priority.
- **BUSY:**
  - `gnt_o[owner]`=1.
  - `det_valid_o = req_i[owner]` and `det_data_o = data_i[owner]`; both are combinational passthroughs.
  - A requester may drop `req_i` mid-frame to stall.
  - An accepted bit with `last_i[owner]`=1 moves to DRAIN.
- **DRAIN:** one cycle with grant low. It exists so that a Moore match on the final bit is sampled. Then goes to CLEAR.
- **Hit detection:**
  - In BUSY and DRAIN, a rising edge of `det_pattern_i` (current high, registered previous low) counts one detection.
  - Each detection increments the frame hit count and `hit_cnt[owner]`.
  - The detector input is ignored in CLEAR and IDLE.
- **Counters:** `clr_cnt_i` has priority over an increment in the same cycle. Counters saturate at all-ones.
- **Reset values:**
  - `gnt_o`=0, `det_valid_o`=0, `det_data_o`=0.
  - `frame_done_o`=0, `frame_abort_o`=0, `frame_id_o`=0, `frame_hits_o`=0.
  - `hit_cnt_o`=0.
  - `det_rst_o`=1, because the block is in CLEAR.
- **Reset mid-frame:** the frame is dropped silently, with no `frame_done_o`.
- **Per-frame outputs:** `frame_id_o` and `frame_hits_o` hold their value until the next `frame_done_o`.

## Timing
- Grant latency: `req_i` seen high in IDLE at edge k gives `gnt_o` high after edge k.
- Throughput: one bit per cycle while the owner holds `req_i`.
- Detector match appears one cycle after the 6th matching bit is accepted and is counted at the following edge.
- Inter-frame gap: DRAIN + CLEAR + IDLE = 3 cycles from the last bit to the next grant.
- `frame_done_o` is high during the CLEAR cycle after DRAIN.

## Configuration
- **With `PDS_TIMEOUT_EN` defined:**
  - In BUSY, a counter increments on every cycle with `req_i[owner]`=0 and resets on any accepted bit.
  - When it reaches `TO_CYC`, the FSM goes straight to CLEAR, skipping DRAIN.
  - `frame_done_o` fires with `frame_abort_o`=1 and the hits counted so far.
- **Without `PDS_TIMEOUT_EN`:** no counter exists, `frame_abort_o` is tied to 0, and a stalled owner holds the detector indefinitely.

## Test plan
- **Single frame:** req0 sends 0,0,1,1,0,1 with `last` on the 6th bit. Expect:
  - `gnt_o`=0001 one cycle after the request.
  - `det_valid_o` high for 6 cycles.
  - `frame_done_o` with id 0 and hits 1; `hit_cnt[0]`=1.
- **Round robin:** req0 and req2 assert together after reset. Expect service order 0, 2. Then re-assert req0 and req3 while 2 is served; expect 3 before 0.
- **Multi-match and isolation:**
  - req1 sends 001101001101 → hits 2.
  - req1 sends 00110 as one frame, then req2 sends 1 → hits 0 for both frames, because `det_rst_o` separates them.
- **Stall:** req0 drops `req_i` for 5 cycles after bit 3 of 001101. Expect `det_valid_o` low for those cycles and hits still 1.
- **Timeout (`PDS_TIMEOUT_EN`, `TO_CYC`=8):** owner stalls for 8 cycles. Expect `frame_done_o` with `frame_abort_o`=1 and hits 0, then the next pending requester granted.
- **Counter clear and saturation:**
  - `clr_cnt_i` in the same cycle as a counted hit → counter reads 0.
  - With `CW`=2, four matches leave the counter at 3.

Source files
------------

// File: rtl/pattern_detect_sched.sv
// pattern_detect_sched: round-robin owner of one shared BBCCBC (B=0, C=1) Moore detector.
// One requester is granted for a whole frame and its bit stream is steered into the detector.
// The detector is reset between frames. Detections are credited to the owner per frame and in
// saturating per-requester totals.
// Optional build macro: PDS_TIMEOUT_EN adds a stall timeout that aborts a stalled frame.
module pattern_detect_sched #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned CW     = 16,
  parameter int unsigned TO_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      data_i,
  input  logic [N_REQ-1:0]      last_i,
  input  logic                  clr_cnt_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic                  det_rst_o,
  output logic                  det_valid_o,
  output logic                  det_data_o,
  input  logic                  det_pattern_i,
  output logic                  frame_done_o,
  output logic [2:0]            frame_id_o,
  output logic [7:0]            frame_hits_o,
  output logic                  frame_abort_o,
  output logic [N_REQ*CW-1:0]   hit_cnt_o
);

  localparam logic [1:0] StClear = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [2:0]    OwnerInit = 3'(N_REQ - 1);
  localparam logic [CW-1:0] CntMax    = '1;
  localparam logic [CW-1:0] CntOne    = CW'(1);

  // Elaboration-time guard on the parameter ranges.
  localparam bit CfgOk = (N_REQ >= 2) && (N_REQ <= 8) && (TO_CYC >= 1) && (CW >= 1);
  if (!CfgOk) begin : gen_cfg_err
    $error("pattern_detect_sched: illegal parameter combination");
  end

  logic [1:0]    state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic          pat_prev_q, pat_prev_d;
  logic [7:0]    fhit_q, fhit_d, fhit_inc;
  logic          fdone_q, fdone_d;
  logic [2:0]    fid_q, fid_d;
  logic [7:0]    fhits_q, fhits_d;
  logic [CW-1:0] hit_cnt_q [N_REQ];
  logic [CW-1:0] hit_cnt_d [N_REQ];

  // Request vectors padded to 8 so a 3-bit owner index always selects in range.
  logic [7:0] req_pad, data_pad, last_pad;
  logic       pick_vld;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       accept;
  logic       abort;
  logic       hit;

`ifdef PDS_TIMEOUT_EN
  localparam int unsigned   ToW    = $clog2(TO_CYC + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TO_CYC - 1);
  localparam logic [ToW-1:0] ToOne  = ToW'(1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           fabort_q, fabort_d;
`endif

  // Pad the per-requester inputs to a fixed 8-bit width.
  always_comb begin
    req_pad              = '0;
    data_pad             = '0;
    last_pad             = '0;
    req_pad[N_REQ-1:0]   = req_i;
    data_pad[N_REQ-1:0]  = data_i;
    last_pad[N_REQ-1:0]  = last_i;
  end

  // Round-robin search starting just above the previous owner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = owner_q;
    cand     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 3'((32'(owner_q) + k) % N_REQ);
      if (!pick_vld && req_pad[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // FSM next state and detector-side outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    det_rst_o   = 1'b0;
    det_valid_o = 1'b0;
    det_data_o  = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    unique case (state_q)
      StClear: begin
        det_rst_o = 1'b1;
        state_d   = StIdle;
      end
      StIdle: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        det_valid_o = req_pad[owner_q];
        det_data_o  = data_pad[owner_q];
        accept      = req_pad[owner_q];
        if (accept && last_pad[owner_q]) begin
          state_d = StDrain;
        end
`ifdef PDS_TIMEOUT_EN
        else if (!accept && (to_cnt_q == ToLast)) begin
          // Stall limit reached: drop straight to CLEAR, skipping DRAIN.
          state_d = StClear;
          abort   = 1'b1;
        end
`endif
      end
      StDrain: begin
        state_d = StClear;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // One-hot grant for the owner while BUSY.
  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt_o[i] = (state_q == StBusy) && (3'(i) == owner_q);
    end
  end

  // Rising-edge detection of the Moore match, only while a frame owns the detector.
  always_comb begin
    hit        = ((state_q == StBusy) || (state_q == StDrain)) && det_pattern_i && !pat_prev_q;
    pat_prev_d = pat_prev_q;
    if (state_q == StClear) begin
      pat_prev_d = 1'b0;
    end else if ((state_q == StBusy) || (state_q == StDrain)) begin
      pat_prev_d = det_pattern_i;
    end
  end

  // Per-frame hit count and completion report.
  always_comb begin
    fhit_inc = fhit_q;
    if (hit && (fhit_q != 8'hFF)) begin
      fhit_inc = fhit_q + 8'd1;
    end
    fhit_d  = (state_q == StClear) ? 8'd0 : fhit_inc;
    fdone_d = 1'b0;
    fid_d   = fid_q;
    fhits_d = fhits_q;
    // A hit counted on the closing edge is still part of the reported frame.
    if ((state_q == StDrain) || abort) begin
      fdone_d = 1'b1;
      fid_d   = owner_q;
      fhits_d = fhit_inc;
    end
  end

  // Saturating per-requester totals; clear wins over a same-cycle increment.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      hit_cnt_d[i] = hit_cnt_q[i];
      if (clr_cnt_i) begin
        hit_cnt_d[i] = '0;
      end else if (hit && (3'(i) == owner_q) && (hit_cnt_q[i] != CntMax)) begin
        hit_cnt_d[i] = hit_cnt_q[i] + CntOne;
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    hit_cnt_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      hit_cnt_o[i*CW +: CW] = hit_cnt_q[i];
    end
  end

  // State registers; reset drops any frame in flight without a completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StClear;
      owner_q    <= OwnerInit;
      pat_prev_q <= 1'b0;
      fhit_q     <= '0;
      fdone_q    <= 1'b0;
      fid_q      <= '0;
      fhits_q    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        hit_cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      pat_prev_q <= pat_prev_d;
      fhit_q     <= fhit_d;
      fdone_q    <= fdone_d;
      fid_q      <= fid_d;
      fhits_q    <= fhits_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        hit_cnt_q[i] <= hit_cnt_d[i];
      end
    end
  end

  assign frame_done_o = fdone_q;
  assign frame_id_o   = fid_q;
  assign frame_hits_o = fhits_q;

`ifdef PDS_TIMEOUT_EN
  // Stall counter: counts owner idle cycles in BUSY, cleared by any accepted bit.
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == StBusy) && !accept && !abort) begin
      to_cnt_d = to_cnt_q + ToOne;
    end
    fabort_d = fabort_q;
    if ((state_q == StDrain) || abort) begin
      fabort_d = abort;
    end
  end

  // Timeout registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      fabort_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      fabort_q <= fabort_d;
    end
  end

  assign frame_abort_o = fabort_q;
`else
  assign frame_abort_o = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_detect_sched.sv
// Directed bench for pattern_detect_sched with a behavioural BBCCBC non-overlapping detector.
module tb_pattern_detect_sched;
  localparam int unsigned NR  = 4;
  localparam int unsigned CWB = 2;
  localparam int unsigned TOC = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, data, last;
  logic              clr;
  logic [NR-1:0]     gnt;
  logic              det_rst, det_valid, det_data, det_pattern;
  logic              frame_done, frame_abort;
  logic [2:0]        frame_id;
  logic [7:0]        frame_hits;
  logic [NR*CWB-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_detect_sched #(.N_REQ(NR), .CW(CWB), .TO_CYC(TOC)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .last_i(last), .clr_cnt_i(clr),
    .gnt_o(gnt), .det_rst_o(det_rst), .det_valid_o(det_valid), .det_data_o(det_data),
    .det_pattern_i(det_pattern), .frame_done_o(frame_done), .frame_id_o(frame_id),
    .frame_hits_o(frame_hits), .frame_abort_o(frame_abort), .hit_cnt_o(hit_cnt)
  );

  // External detector: state k = first k symbols of 001101 matched, 6 = match (Moore).
  logic [2:0] dst_q = 3'd0;
  always @(posedge clk) begin
    if (det_rst) dst_q <= 3'd0;
    else if (det_valid) begin
      case (dst_q)
        3'd0:    dst_q <= det_data ? 3'd0 : 3'd1;
        3'd1:    dst_q <= det_data ? 3'd0 : 3'd2;
        3'd2:    dst_q <= det_data ? 3'd3 : 3'd2;
        3'd3:    dst_q <= det_data ? 3'd4 : 3'd1;
        3'd4:    dst_q <= det_data ? 3'd0 : 3'd5;
        3'd5:    dst_q <= det_data ? 3'd6 : 3'd2;
        default: dst_q <= det_data ? 3'd0 : 3'd1;
      endcase
    end
  end
  assign det_pattern = (dst_q == 3'd6);

  task automatic test_reset();
    rst = 1'b1; req = '0; data = '0; last = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt got %b want 0", gnt); end
    checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL rst_det_rst got %b want 1", det_rst); end
    checks++; if ({det_valid, det_data} !== 2'b00) begin errors++; $display("FAIL rst_det_io got %b want 00", {det_valid, det_data}); end
    checks++; if ({frame_done, frame_abort, frame_id, frame_hits} !== 13'd0) begin
      errors++; $display("FAIL rst_frame got %b/%b/%0d/%0d want 0", frame_done, frame_abort, frame_id, frame_hits); end
    checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL rst_hit_cnt got %h want 0", hit_cnt); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({frame_done, det_rst} !== 2'b01) begin errors++; $display("FAIL rst_clear got done=%b det_rst=%b want 0/1", frame_done, det_rst); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (det_rst !== 1'b0) begin errors++; $display("FAIL rst_idle_det_rst got %b want 0", det_rst); end
    @(posedge clk); #1;
  endtask

  // Cycle table: req per cycle, expected grant, and expected completion owner (7 = no pulse).
  task automatic test_round_robin();
    logic [3:0] t_req [17] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b1101, 4'b1001,
                               4'b1001, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0000, 4'b0000, 4'b0000};
    logic [3:0] t_gnt [17] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
                               4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                               4'b0000, 4'b0000, 4'b0000};
    logic [2:0] t_id  [17] = '{7, 7, 7, 0, 7, 7, 7, 2, 7, 7, 7, 3, 7, 7, 7, 0, 7};
    data = '0; last = '1;
    for (int c = 0; c < 17; c++) begin
      req = t_req[c];
      @(negedge clk);
      checks++; if (gnt !== t_gnt[c]) begin errors++; $display("FAIL rr_gnt cyc %0d got %b want %b", c, gnt, t_gnt[c]); end
      checks++; if (frame_done !== (t_id[c] != 3'd7)) begin errors++; $display("FAIL rr_done cyc %0d got %b", c, frame_done); end
      if (t_id[c] != 3'd7) begin
        checks++; if ({frame_id, frame_hits} !== {t_id[c], 8'd0}) begin
          errors++; $display("FAIL rr_frame cyc %0d got id %0d hits %0d want id %0d hits 0", c, frame_id, frame_hits, t_id[c]); end
      end
      @(posedge clk); #1;
    end
    req = '0; last = '0;
  endtask

  // Sends one frame from idle for requester r; bits are sent MSB-first from bits[n-1].
  task automatic run_frame(input int r, input logic [15:0] bits, input int n, input int stall_after,
                           input int stall_len, input logic clr_at_drain, input logic [7:0] exp_hits,
                           input logic [CWB-1:0] exp_cnt);
    int idx = 0, stall = 0, vcnt = 0, cyc = 0;
    logic acc;
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    req[r] = 1'b1; data[r] = bits[n-1]; last[r] = (n == 1);
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL frame_gnt_idle r%0d got %b want 0", r, gnt); end
    @(posedge clk); #1;
    while (idx < n && cyc < 100) begin
      @(negedge clk);
      checks++; if (gnt !== oh) begin errors++; $display("FAIL frame_gnt r%0d bit %0d got %b want %b", r, idx, gnt, oh); end
      checks++; if (det_valid !== req[r]) begin errors++; $display("FAIL frame_valid r%0d bit %0d got %b want %b", r, idx, det_valid, req[r]); end
      if (req[r]) begin
        checks++; if (det_data !== data[r]) begin errors++; $display("FAIL frame_data r%0d bit %0d got %b want %b", r, idx, det_data, data[r]); end
      end
      if (det_valid) vcnt++;
      acc = req[r];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx == stall_after) stall = stall_len;
      end else if (stall > 0) stall--;
      if (idx >= n) begin req[r] = 1'b0; last[r] = 1'b0; data[r] = 1'b0; end
      else if (stall > 0) req[r] = 1'b0;
      else begin req[r] = 1'b1; data[r] = bits[n-1-idx]; last[r] = (idx == n - 1); end
    end
    checks++; if (idx != n) begin errors++; $display("FAIL frame_budget r%0d sent %0d want %0d", r, idx, n); end
    clr = clr_at_drain;
    @(negedge clk);
    checks++; if ({gnt, det_valid} !== '0) begin errors++; $display("FAIL frame_drain r%0d got gnt %b valid %b want 0", r, gnt, det_valid); end
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    checks++; if ({frame_done, frame_abort, det_rst} !== 3'b101) begin
      errors++; $display("FAIL frame_done r%0d got done %b abort %b det_rst %b want 1/0/1", r, frame_done, frame_abort, det_rst); end
    checks++; if (frame_id !== 3'(r)) begin errors++; $display("FAIL frame_id got %0d want %0d", frame_id, r); end
    checks++; if (frame_hits !== exp_hits) begin errors++; $display("FAIL frame_hits r%0d got %0d want %0d", r, frame_hits, exp_hits); end
    checks++; if (hit_cnt[r*CWB +: CWB] !== exp_cnt) begin
      errors++; $display("FAIL hit_cnt r%0d got %0d want %0d", r, hit_cnt[r*CWB +: CWB], exp_cnt); end
    checks++; if (vcnt != n) begin errors++; $display("FAIL valid_cycles r%0d got %0d want %0d", r, vcnt, n); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse r%0d got %b want 0", r, frame_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    run_frame(0, 16'b001101, 6, 0, 0, 1'b0, 8'd1, 2'd1);
  endtask

  task automatic test_multi_match();
    run_frame(1, 16'b001101001101, 12, 0, 0, 1'b0, 8'd2, 2'd2);
  endtask

  task automatic test_isolation();
    run_frame(1, 16'b00110, 5, 0, 0, 1'b0, 8'd0, 2'd2);
    run_frame(2, 16'b1, 1, 0, 0, 1'b0, 8'd0, 2'd0);
  endtask

  task automatic test_stall();
    run_frame(0, 16'b001101, 6, 3, 5, 1'b0, 8'd1, 2'd2);
  endtask

  task automatic test_saturation();
    run_frame(0, 16'b001101001101, 12, 0, 0, 1'b0, 8'd2, 2'd3);
  endtask

  task automatic test_clear();
    run_frame(1, 16'b001101, 6, 0, 0, 1'b1, 8'd1, 2'd0);
    checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL clr_all got %h want 0", hit_cnt); end
    run_frame(2, 16'b001101, 6, 0, 0, 1'b0, 8'd1, 2'd1);
  endtask

`ifdef PDS_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] t_req [16] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                               4'b0000, 4'b0000};
    logic [3:0] t_gnt [16] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                               4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                               4'b0000, 4'b0000};
    data = '0; last = 4'b1000;
    for (int c = 0; c < 16; c++) begin
      req = t_req[c];
      @(negedge clk);
      checks++; if (gnt !== t_gnt[c]) begin errors++; $display("FAIL to_gnt cyc %0d got %b want %b", c, gnt, t_gnt[c]); end
      checks++; if (frame_done !== (c == 10 || c == 14)) begin errors++; $display("FAIL to_done cyc %0d got %b", c, frame_done); end
      if (c == 10) begin
        checks++; if ({frame_abort, frame_id, frame_hits} !== {1'b1, 3'd2, 8'd0}) begin
          errors++; $display("FAIL to_abort got abort %b id %0d hits %0d want 1/2/0", frame_abort, frame_id, frame_hits); end
      end
      if (c == 14) begin
        checks++; if ({frame_abort, frame_id} !== {1'b0, 3'd3}) begin
          errors++; $display("FAIL to_next got abort %b id %0d want 0/3", frame_abort, frame_id); end
      end
      @(posedge clk); #1;
    end
    req = '0; last = '0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    data = '0; last = '0; req = 4'b0010;
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b want 0010", gnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, det_rst} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL mid_clear got gnt %b det_rst %b", gnt, det_rst); end
    checks++; if ({frame_id, frame_hits} !== 11'd0) begin errors++; $display("FAIL mid_frame_regs got id %0d hits %0d want 0", frame_id, frame_hits); end
    checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL mid_hit_cnt got %h want 0", hit_cnt); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_done cyc %0d got %b want 0", c, frame_done); end
      @(posedge clk); #1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_frame();
    test_multi_match();
    test_isolation();
    test_stall();
    test_saturation();
    test_clear();
`ifdef PDS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
